alu_issue_arbiter: RTL and testbench

//  Shares the single-cycle ALU among NUM_REQ issue sources using a round-robin scheme.
//  The ALU is combinational, so this block drives it directly.

---
 rtl/alu_issue_arbiter_pkg.sv | 63 ++++++
 rtl/alu_issue_arbiter_rr.sv | 68 ++++++
 rtl/alu_issue_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_issue_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_arbiter_pkg
// Purpose : shared types for the ALU issue path. This covers the functional-unit
//           operation record, the result record with its exception payload,
//           and the depth of the ALU result buffer.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package alu_issue_arbiter_pkg;

  localparam int XLEN                 = 64;
  localparam int TRANS_ID_BITS        = 3;
  localparam int ALU_RESULT_BUF_DEPTH = 2;

  typedef enum logic [3:0] {
    FU_NONE      = 4'd0,
    FU_ALU       = 4'd1,
    FU_LSU       = 4'd2,
    FU_MUL       = 4'd3,
    FU_CTRL_FLOW = 4'd4
  } fu_t;

  typedef enum logic [5:0] {
    OP_ADD  = 6'd0,
    OP_SUB  = 6'd1,
    OP_AND  = 6'd2,
    OP_OR   = 6'd3,
    OP_XOR  = 6'd4,
    OP_SLL  = 6'd5,
    OP_SRL  = 6'd6,
    OP_SRA  = 6'd7,
    OP_SLT  = 6'd8,
    OP_SLTU = 6'd9,
    OP_JALR = 6'd10
  } fu_op_t;

  // Exception causes raised by the ALU path.
  localparam logic [XLEN-1:0] CAUSE_INSTR_ADDR_MISALIGNED = 64'd0;
  localparam logic [XLEN-1:0] CAUSE_ILLEGAL_INSTR         = 64'd2;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    fu_t                      fu;
    fu_op_t                   operation;
    logic [XLEN-1:0]          operand_a;
    logic [XLEN-1:0]          operand_b;
    logic [XLEN-1:0]          imm;
    logic [TRANS_ID_BITS-1:0] index;
    logic [4:0]               rd;
  } fu_data_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] index;
    logic [4:0]               rd;
    logic [XLEN-1:0]          result;
    exception_t               ex;
  } fu_result_t;

endpackage

// File: rtl/alu_issue_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purpose : round-robin arbiter with its own priority pointer. The search
//           starts at the pointer and wraps modulo N, and the first requester
//           found wins. The pointer moves to one past the winner when en is
//           high. This arbiter is shared by the ALU, LSU and MUL issue ports.
// Ports   :
//   clk         in   1       clock, rising edge
//   rst_n       in   1       asynchronous reset, active-low (pointer -> 0)
//   req         in   N       request vector
//   en          in   1       grant accepted this cycle; advance the pointer
//   gnt_onehot  out  N       one-hot winner (0 when no request)
//   gnt_idx     out  IW      winner index; equals the pointer when no request
//   any         out  1       at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] ptr_q;

  // The sum is one bit wider than the index so that ptr+i can be folded back
  // into range for any N, including N values that are not powers of two.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    gnt_idx = ptr_q;
    any     = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      cand = sum[IW-1:0];
      if (!any && req[cand]) begin
        any     = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    gnt_onehot = '0;
    if (any) begin
      gnt_onehot[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (en) begin
      ptr_q <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// ---------------------------------------------------------------------------
// alu_issue_arbiter
// Purpose : shares the single-cycle combinational ALU among NUM_REQ issue
//           sources in round-robin order. Each ALU result is captured in a
//           2-entry FIFO, so the ready signal from writeback never reaches
//           the issue path combinationally.
// Ports   :
//   clk_i               in   1                   clock, rising edge
//   rst_ni              in   1                   asynchronous reset, active-low
//   flush_i             in   1                   discard all buffered results
//   req_valid_i         in   NUM_REQ             per-requester operation valid
//   req_ready_o         out  NUM_REQ             one-hot accept to the winner
//   req_data_i          in   NUM_REQ x fu_data_t per-requester operation
//   alu_valid_o         out  1                   operation valid to ALU
//   alu_ready_i         in   1                   ALU can accept
//   alu_data_o          out  fu_data_t           operation to ALU
//   alu_result_valid_i  in   1                   ALU result valid
//   alu_result_ready_o  out  1                   buffer has room
//   alu_result_i        in   fu_result_t         ALU result
//   wb_valid_o          out  1                   head entry valid
//   wb_ready_i          in   1                   writeback takes head
//   wb_result_o         out  fu_result_t         head entry
// ---------------------------------------------------------------------------
module alu_issue_arbiter
  import alu_issue_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BUF_DEPTH = ALU_RESULT_BUF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  fu_data_t [NUM_REQ-1:0]   req_data_i,
  output logic                     alu_valid_o,
  input  logic                     alu_ready_i,
  output fu_data_t                 alu_data_o,
  input  logic                     alu_result_valid_i,
  output logic                     alu_result_ready_o,
  input  fu_result_t               alu_result_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output fu_result_t               wb_result_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [NUM_REQ-1:0] gnt_onehot;
  logic [IW-1:0]      gnt_idx;
  logic               any_req;
  logic               fire;
  logic               push;
  logic               pop;

  // The buffer is exactly two entries deep, so the head and tail pointers are
  // single bits that wrap naturally from 1 to 0.
  fu_result_t         buf_q [BUF_DEPTH];
  logic               head_q;
  logic               tail_q;
  logic [CW-1:0]      count_q;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .req        (req_valid_i),
    .en         (fire),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any_req)
  );

  // Issue side. Holding reset blocks alu_valid_o and every grant, even while
  // the requesters keep toggling.
  assign alu_valid_o = rst_ni & any_req;
  // When no request is present, gnt_idx is the pointer, so the mux shows the
  // operation of the next requester in priority order.
  assign alu_data_o  = req_data_i[gnt_idx];
  assign fire        = alu_valid_o & alu_ready_i & ~flush_i;
  assign req_ready_o = fire ? gnt_onehot : '0;

  // Result buffer. There is no bypass when the buffer is full; a slot only
  // frees up on the cycle after a pop.
  assign alu_result_ready_o = (count_q != CW'(BUF_DEPTH));
  assign push               = alu_result_valid_i & alu_result_ready_o & ~flush_i;
  assign wb_valid_o         = (count_q != '0);
  assign pop                = wb_valid_o & wb_ready_i;
  assign wb_result_o        = buf_q[head_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
    end else if (flush_i) begin
      // A pop in the flush cycle does not matter; everything is discarded.
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
    end else begin
      if (push) begin
        buf_q[tail_q] <= alu_result_i;
        tail_q        <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
module tb_alu_issue_arbiter;
  import alu_issue_arbiter_pkg::*;

  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flush;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  fu_data_t [N-1:0]     req_data;
  logic                 alu_valid;
  logic                 alu_ready;
  fu_data_t             alu_data;
  logic                 alu_result_valid;
  logic                 alu_result_ready;
  fu_result_t           alu_result;
  logic                 wb_valid;
  logic                 wb_ready;
  fu_result_t           wb_result;

  int         checks = 0;
  int         errors = 0;
  int         m_count = 0;
  fu_result_t sb[$];

  typedef struct {
    logic [N-1:0] req_valid;
    logic         wb_ready;
    logic [N-1:0] exp_gnt;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  alu_issue_arbiter #(.NUM_REQ(N)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .flush_i            (flush),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_data_i         (req_data),
    .alu_valid_o        (alu_valid),
    .alu_ready_i        (alu_ready),
    .alu_data_o         (alu_data),
    .alu_result_valid_i (alu_result_valid),
    .alu_result_ready_o (alu_result_ready),
    .alu_result_i       (alu_result),
    .wb_valid_o         (wb_valid),
    .wb_ready_i         (wb_ready),
    .wb_result_o        (wb_result)
  );

  function automatic fu_result_t alu_func(input fu_data_t d);
    fu_result_t  r;
    logic [63:0] t;
    r       = '0;
    r.index = d.index;
    r.rd    = d.rd;
    t       = '0;
    case (d.operation)
      OP_ADD:  r.result = d.operand_a + d.operand_b;
      OP_SUB:  r.result = d.operand_a - d.operand_b;
      OP_JALR: begin
        t        = (d.operand_a + d.imm) & ~64'd1;
        r.result = t;
        if (t[1]) begin
          r.ex.valid = 1'b1;
          r.ex.cause = CAUSE_INSTR_ADDR_MISALIGNED;
          r.ex.tval  = t;
        end
      end
      default: r.result = '0;
    endcase
    return r;
  endfunction

  // Combinational single-cycle ALU: it accepts whenever the result buffer
  // has room and returns the result in the same cycle.
  always_comb begin
    alu_ready        = alu_result_ready;
    alu_result_valid = alu_valid & alu_ready;
    alu_result       = alu_func(alu_data);
  end

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle. It is called at a negedge, and it returns at the next
  // negedge.
  task automatic cyc(input logic [N-1:0] rv, input logic wbr, input logic fl,
                     input logic [N-1:0] gnt);
    int         w;
    fu_result_t exp_r;
    w = 0;
    req_valid = rv;
    wb_ready  = wbr;
    flush     = fl;
    #1;
    chk("req_ready", 256'(req_ready), 256'(gnt));
    chk("alu_valid", 256'(alu_valid), 256'(|rv));
    chk("wb_valid", 256'(wb_valid), 256'(m_count != 0));
    chk("alu_result_ready", 256'(alu_result_ready), 256'(m_count != 2));
    if (m_count != 0 && wbr) begin
      exp_r = sb.pop_front();
      chk("wb_result", 256'(wb_result), 256'(exp_r));
      m_count--;
    end
    if (gnt != '0) begin
      w = onehot_idx(gnt);
      sb.push_back(alu_func(req_data[w]));
      m_count++;
    end
    if (fl) begin
      sb.delete();
      m_count = 0;
    end
    @(posedge clk);
    @(negedge clk);
    if (gnt != '0) req_data[w].operand_a = req_data[w].operand_a + 64'd16;
  endtask

  task automatic add(input logic [N-1:0] rv, input logic wbr, input logic [N-1:0] gnt);
    vec_t v;
    v.req_valid = rv;
    v.wb_ready  = wbr;
    v.exp_gnt   = gnt;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Round robin with all four requesters valid, then a drain cycle.
    for (int i = 0; i < 8; i++) add(4'hF, 1'b1, 4'(1 << (i % 4)));
    add(4'h0, 1'b1, 4'h0);
    // Sparse requests: the pointer moves to 1, only req3 is valid, the pointer wraps to 0, then req0.
    add(4'h1, 1'b1, 4'h1);
    add(4'h8, 1'b1, 4'h8);
    add(4'h1, 1'b1, 4'h1);
    add(4'h5, 1'b1, 4'h4);
    add(4'h3, 1'b1, 4'h1);
    add(4'h3, 1'b1, 4'h2);
    add(4'h0, 1'b1, 4'h0);
    // Steady stream: the count stays at 1, with one retire per cycle.
    for (int i = 0; i < 10; i++) add(4'h1, 1'b1, 4'h1);
    add(4'h0, 1'b1, 4'h0);

    for (int i = 0; i < N; i++) begin
      req_data[i]           = '0;
      req_data[i].fu        = FU_ALU;
      req_data[i].operation = OP_ADD;
      req_data[i].operand_a = 64'(i * 1000 + 1);
      req_data[i].operand_b = 64'(i + 7);
      req_data[i].index     = 3'(i);
      req_data[i].rd        = 5'(i + 1);
    end
    rst_n = 1'b0; flush = 1'b0; req_valid = '0; wb_ready = 1'b0;

    // T1: hold reset with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 4'($urandom);
      wb_ready  = 1'($urandom);
      flush     = 1'($urandom);
      #1;
      chk("rst_wb_valid", 256'(wb_valid), 256'(0));
      chk("rst_req_ready", 256'(req_ready), 256'(0));
      chk("rst_alu_valid", 256'(alu_valid), 256'(0));
      chk("rst_wb_result", 256'(wb_result), 256'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;

    // T2 / T6 / T4 table.
    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].req_valid, tbl[i].wb_ready, 1'b0, tbl[i].exp_gnt);

    // T3: backpressure. The pointer is 1 and the buffer is empty.
    req_data[0].operation = OP_ADD; req_data[0].operand_a = 64'd1; req_data[0].operand_b = 64'd2;
    cyc(4'h1, 1'b0, 1'b0, 4'h1);
    req_data[0].operation = OP_SUB; req_data[0].operand_a = 64'd5; req_data[0].operand_b = 64'd7;
    cyc(4'h1, 1'b0, 1'b0, 4'h1);
    chk("t3_head_add", 256'(wb_result.result), 256'(64'd3));
    req_data[0].operation = OP_ADD; req_data[0].operand_a = 64'd9; req_data[0].operand_b = 64'd9;
    cyc(4'h1, 1'b0, 1'b0, 4'h0);
    cyc(4'h1, 1'b1, 1'b0, 4'h0);
    chk("t3_head_sub", 256'(wb_result.result), 256'(64'hFFFF_FFFF_FFFF_FFFE));
    cyc(4'h1, 1'b1, 1'b0, 4'h1);
    cyc(4'h0, 1'b1, 1'b0, 4'h0);

    // T5: flush while the buffer is full and req2 is pending. The pointer stays at 2.
    cyc(4'h2, 1'b0, 1'b0, 4'h2);
    cyc(4'h2, 1'b0, 1'b0, 4'h2);
    cyc(4'h4, 1'b0, 1'b1, 4'h0);
    cyc(4'h6, 1'b1, 1'b0, 4'h4);
    cyc(4'h1, 1'b1, 1'b1, 4'h0);
    cyc(4'h9, 1'b0, 1'b0, 4'h8);
    cyc(4'h0, 1'b1, 1'b0, 4'h0);

    // T6: JALR with a misaligned target. The pointer is 0, so req2 wins.
    req_data[2].operation = OP_JALR;
    req_data[2].operand_a = 64'h1000;
    req_data[2].operand_b = 64'd0;
    req_data[2].imm       = 64'd2;
    cyc(4'h4, 1'b0, 1'b0, 4'h4);
    chk("jalr_ex_valid", 256'(wb_result.ex.valid), 256'(1));
    chk("jalr_tval", 256'(wb_result.ex.tval), 256'(64'h1002));
    cyc(4'h0, 1'b1, 1'b0, 4'h0);

    // Reset asserted mid-operation with two entries buffered and the pointer at 1.
    cyc(4'hF, 1'b0, 1'b0, 4'h8);
    cyc(4'hF, 1'b0, 1'b0, 4'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_wb_valid", 256'(wb_valid), 256'(0));
    chk("midrst_req_ready", 256'(req_ready), 256'(0));
    chk("midrst_alu_valid", 256'(alu_valid), 256'(0));
    sb.delete();
    m_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'hF, 1'b1, 1'b0, 4'h1);
    cyc(4'h0, 1'b1, 1'b0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
